// File: rtl/nv_nvdla_rbk_cvif_rd_rsp_rx_if.sv
// CVIF read-response ingress and RBK atom egress bundle.
// master drives responses and atom accept; slave is the receiver.
interface nv_nvdla_rbk_cvif_rd_rsp_rx_if #(
    parameter int IDW = 514,
    parameter int ODW = 256
) ();
    logic           cvif2rbk_rd_rsp_valid;
    logic           cvif2rbk_rd_rsp_ready;
    logic [IDW-1:0] cvif2rbk_rd_rsp_pd;
    logic           rbk_rsp_vld;
    logic           rbk_rsp_rdy;
    logic [ODW-1:0] rbk_rsp_data;
    logic           rbk_rsp_last;
    logic           rbk_rsp_mask_err;

    modport master (
        output cvif2rbk_rd_rsp_valid,
        input  cvif2rbk_rd_rsp_ready,
        output cvif2rbk_rd_rsp_pd,
        input  rbk_rsp_vld,
        output rbk_rsp_rdy,
        input  rbk_rsp_data,
        input  rbk_rsp_last,
        input  rbk_rsp_mask_err
    );

    modport slave (
        input  cvif2rbk_rd_rsp_valid,
        output cvif2rbk_rd_rsp_ready,
        input  cvif2rbk_rd_rsp_pd,
        output rbk_rsp_vld,
        input  rbk_rsp_rdy,
        output rbk_rsp_data,
        output rbk_rsp_last,
        output rbk_rsp_mask_err
    );
endinterface

// File: rtl/nv_nvdla_rbk_cvif_rd_rsp_rx.sv
// CVIF read-response receiver: FIFO plus mask-driven unpack
// of 512-bit responses into 256-bit atoms for RBK.
module nv_nvdla_rbk_cvif_rd_rsp_rx #(
    parameter int IDW   = 514,
    parameter int ODW   = 256,
    parameter int DEPTH = 4
) (
    input logic nvdla_core_clk,
    input logic nvdla_core_rstn,
    nv_nvdla_rbk_cvif_rd_rsp_rx_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [IDW-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           hi_pend;
    logic           err_q;

    logic [IDW-1:0] head;
    logic [1:0]     m;
    logic           empty;
    logic           ready;
    logic           push;
    logic           vld;
    logic           acc;
    logic           pop;

    assign head  = mem[rd_ptr];
    assign m     = head[IDW-1 -: 2];
    assign empty = (count == '0);
    assign ready = (count < CW'(DEPTH));
    assign push  = bus.cvif2rbk_rd_rsp_valid && ready;
    assign vld   = !empty && (m != 2'b00);
    assign acc   = vld && bus.rbk_rsp_rdy;

    // an empty mask is retired without ever presenting an atom
    assign pop = !empty &&
                 ((m == 2'b00) ||
                  (acc && ((m != 2'b11) || hi_pend)));

    assign bus.cvif2rbk_rd_rsp_ready = ready;
    assign bus.rbk_rsp_vld           = vld;
    assign bus.rbk_rsp_last          = vld && (hi_pend || (m != 2'b11));
    assign bus.rbk_rsp_mask_err      = err_q;
    assign bus.rbk_rsp_data          = (hi_pend || (m == 2'b10))
                                     ? head[2*ODW-1 -: ODW]
                                     : head[ODW-1:0];

    always_ff @(posedge nvdla_core_clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.cvif2rbk_rd_rsp_pd;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            hi_pend <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (pop) begin
                hi_pend <= 1'b0;
            end else if (acc && (m == 2'b11)) begin
                hi_pend <= 1'b1;
            end
            err_q <= !empty && (m == 2'b00);
        end
    end
endmodule

// File: tb/tb_nv_nvdla_rbk_cvif_rd_rsp_rx.sv
// Self-checking bench for the CVIF read-response receiver.
// Reference model: queue of expected {last,data} atoms.
module tb_nv_nvdla_rbk_cvif_rd_rsp_rx;
    localparam int IDW = 514;
    localparam int ODW = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    nv_nvdla_rbk_cvif_rd_rsp_rx_if #(.IDW(IDW), .ODW(ODW)) bus ();

    nv_nvdla_rbk_cvif_rd_rsp_rx #(
        .IDW(IDW), .ODW(ODW), .DEPTH(4)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rst_n),
        .bus            (bus)
    );

    function automatic logic [513:0] mk_pd(input logic [1:0] m);
        logic [513:0] p;
        p[513:512] = m;
        for (int i = 0; i < 16; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic settle();
        bus.cvif2rbk_rd_rsp_valid = 1'b0;
        bus.rbk_rsp_rdy = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [513:0] p;
        p = mk_pd(2'b01);
        rst_n = 1'b0;
        bus.cvif2rbk_rd_rsp_valid = 1'b1;
        bus.cvif2rbk_rd_rsp_pd = p;
        bus.rbk_rsp_rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (bus.cvif2rbk_rd_rsp_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL rst_ready: got %b want 1", bus.cvif2rbk_rd_rsp_ready);
            end
            n_cmp++;
            if (bus.rbk_rsp_vld !== 1'b0 || bus.rbk_rsp_last !== 1'b0 ||
                bus.rbk_rsp_mask_err !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_outs: got vld=%b last=%b err=%b want 0 0 0",
                         bus.rbk_rsp_vld, bus.rbk_rsp_last, bus.rbk_rsp_mask_err);
            end
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.rbk_rsp_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL rel_vld: got %b want 0", bus.rbk_rsp_vld);
        end
        @(posedge clk);
        #1;
        bus.cvif2rbk_rd_rsp_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.rbk_rsp_vld !== 1'b1 || bus.rbk_rsp_data !== p[255:0] ||
            bus.rbk_rsp_last !== 1'b1) begin
            n_bad++;
            $display("FAIL first_push: got vld=%b last=%b data=%h want 1 1 %h",
                     bus.rbk_rsp_vld, bus.rbk_rsp_last, bus.rbk_rsp_data, p[255:0]);
        end
        settle();
    endtask

    task automatic test_mask11();
        logic [513:0] p;
        p = mk_pd(2'b11);
        bus.cvif2rbk_rd_rsp_valid = 1'b1;
        bus.cvif2rbk_rd_rsp_pd = p;
        bus.rbk_rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.cvif2rbk_rd_rsp_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.rbk_rsp_vld !== 1'b1 || bus.rbk_rsp_data !== p[255:0] ||
            bus.rbk_rsp_last !== 1'b0) begin
            n_bad++;
            $display("FAIL m11_lo: got vld=%b last=%b data=%h want 1 0 %h",
                     bus.rbk_rsp_vld, bus.rbk_rsp_last, bus.rbk_rsp_data, p[255:0]);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.rbk_rsp_vld !== 1'b1 || bus.rbk_rsp_data !== p[511:256] ||
            bus.rbk_rsp_last !== 1'b1) begin
            n_bad++;
            $display("FAIL m11_hi: got vld=%b last=%b data=%h want 1 1 %h",
                     bus.rbk_rsp_vld, bus.rbk_rsp_last, bus.rbk_rsp_data, p[511:256]);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.rbk_rsp_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL m11_end: got vld=%b want 0", bus.rbk_rsp_vld);
        end
        settle();
    endtask

    task automatic test_full();
        logic [513:0] p [4];
        bus.rbk_rsp_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p[i] = mk_pd(2'b01);
            bus.cvif2rbk_rd_rsp_valid = 1'b1;
            bus.cvif2rbk_rd_rsp_pd = p[i];
            @(negedge clk);
            n_cmp++;
            if (bus.cvif2rbk_rd_rsp_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL fill_ready%0d: got %b want 1", i, bus.cvif2rbk_rd_rsp_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.cvif2rbk_rd_rsp_pd = mk_pd(2'b10);
        @(negedge clk);
        n_cmp++;
        if (bus.cvif2rbk_rd_rsp_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_ready: got %b want 0", bus.cvif2rbk_rd_rsp_ready);
        end
        @(posedge clk);
        #1;
        bus.rbk_rsp_rdy = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.cvif2rbk_rd_rsp_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL popcyc_ready: got %b want 0", bus.cvif2rbk_rd_rsp_ready);
        end
        @(posedge clk);
        #1;
        bus.cvif2rbk_rd_rsp_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.cvif2rbk_rd_rsp_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL after_pop_ready: got %b want 1", bus.cvif2rbk_rd_rsp_ready);
        end
        for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (bus.rbk_rsp_vld !== 1'b1 || bus.rbk_rsp_data !== p[i][255:0]) begin
                n_bad++;
                $display("FAIL drain%0d: got vld=%b data=%h want 1 %h",
                         i, bus.rbk_rsp_vld, bus.rbk_rsp_data, p[i][255:0]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bus.rbk_rsp_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_end: got vld=%b want 0 (extra push at full?)", bus.rbk_rsp_vld);
        end
        settle();
    endtask

    task automatic test_mask00();
        logic [513:0] p [3];
        logic [255:0] got [$];
        int err_cyc;
        err_cyc = 0;
        p[0] = mk_pd(2'b01);
        p[1] = mk_pd(2'b00);
        p[2] = mk_pd(2'b01);
        bus.rbk_rsp_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.cvif2rbk_rd_rsp_valid = (i < 3);
            if (i < 3) bus.cvif2rbk_rd_rsp_pd = p[i];
            @(negedge clk);
            if (bus.rbk_rsp_vld === 1'b1) got.push_back(bus.rbk_rsp_data);
            if (bus.rbk_rsp_mask_err === 1'b1) err_cyc++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (got.size() != 2) begin
            n_bad++;
            $display("FAIL m00_count: got %0d atoms want 2", got.size());
        end else begin
            n_cmp++;
            if (got[0] !== p[0][255:0] || got[1] !== p[2][255:0]) begin
                n_bad++;
                $display("FAIL m00_data: got %h,%h want %h,%h",
                         got[0], got[1], p[0][255:0], p[2][255:0]);
            end
        end
        n_cmp++;
        if (err_cyc != 1) begin
            n_bad++;
            $display("FAIL m00_err: got %0d pulse cycles want 1", err_cyc);
        end
        settle();
    endtask

    task automatic test_random();
        logic [256:0] exp_q [$];
        logic [256:0] e;
        logic [1:0]   m;
        logic [255:0] sd;
        logic         sl;
        logic         stall;
        logic         took;
        int sent, exp_atoms, seen, exp_err, seen_err, cyc, idle;
        sent = 0; exp_atoms = 0; seen = 0; exp_err = 0;
        seen_err = 0; cyc = 0; idle = 0;
        stall = 1'b0; took = 1'b0; sd = '0; sl = 1'b0;
        bus.cvif2rbk_rd_rsp_valid = 1'b0;
        while ((sent < 1000 || exp_q.size() != 0 || idle < 10) && cyc < 30000) begin
            if (!bus.cvif2rbk_rd_rsp_valid || took) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    bus.cvif2rbk_rd_rsp_valid = 1'b1;
                    bus.cvif2rbk_rd_rsp_pd = mk_pd(2'($urandom_range(0, 3)));
                end else begin
                    bus.cvif2rbk_rd_rsp_valid = 1'b0;
                end
            end
            bus.rbk_rsp_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            cyc++;
            if (stall) begin
                n_cmp++;
                if (bus.rbk_rsp_vld !== 1'b1 || bus.rbk_rsp_data !== sd ||
                    bus.rbk_rsp_last !== sl) begin
                    n_bad++;
                    $display("FAIL stall_stable: got vld=%b last=%b data=%h want 1 %b %h",
                             bus.rbk_rsp_vld, bus.rbk_rsp_last, bus.rbk_rsp_data, sl, sd);
                end
            end
            if (bus.rbk_rsp_mask_err === 1'b1) seen_err++;
            if (bus.rbk_rsp_vld === 1'b1 && bus.rbk_rsp_rdy) begin
                seen++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand_extra: got atom %h want none", bus.rbk_rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.rbk_rsp_last, bus.rbk_rsp_data} !== e) begin
                        n_bad++;
                        $display("FAIL rand_atom: got last=%b data=%h want last=%b data=%h",
                                 bus.rbk_rsp_last, bus.rbk_rsp_data, e[256], e[255:0]);
                    end
                end
            end
            took = bus.cvif2rbk_rd_rsp_valid && bus.cvif2rbk_rd_rsp_ready;
            if (took) begin
                sent++;
                m = bus.cvif2rbk_rd_rsp_pd[513:512];
                if (m[0]) exp_q.push_back({!m[1], bus.cvif2rbk_rd_rsp_pd[255:0]});
                if (m[1]) exp_q.push_back({1'b1, bus.cvif2rbk_rd_rsp_pd[511:256]});
                if (m == 2'b00) exp_err++;
                exp_atoms += int'(m[0]) + int'(m[1]);
            end
            stall = (bus.rbk_rsp_vld === 1'b1) && !bus.rbk_rsp_rdy;
            sd = bus.rbk_rsp_data;
            sl = bus.rbk_rsp_last;
            if (sent >= 1000 && exp_q.size() == 0) idle++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (cyc >= 30000) begin
            n_bad++;
            $display("FAIL rand_timeout: got %0d sent %0d left want drained", sent, exp_q.size());
        end
        n_cmp++;
        if (seen != exp_atoms) begin
            n_bad++;
            $display("FAIL rand_atoms: got %0d want %0d", seen, exp_atoms);
        end
        n_cmp++;
        if (seen_err != exp_err) begin
            n_bad++;
            $display("FAIL rand_errs: got %0d want %0d", seen_err, exp_err);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        logic [513:0] pa;
        logic [513:0] pc;
        pa = mk_pd(2'b11);
        pc = mk_pd(2'b11);
        bus.cvif2rbk_rd_rsp_valid = 1'b1;
        bus.cvif2rbk_rd_rsp_pd = pa;
        bus.rbk_rsp_rdy = 1'b0;
        @(posedge clk);
        #1;
        bus.cvif2rbk_rd_rsp_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.rbk_rsp_data !== pa[255:0] || bus.rbk_rsp_last !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_a: got last=%b data=%h want 0 %h",
                     bus.rbk_rsp_last, bus.rbk_rsp_data, pa[255:0]);
        end
        @(posedge clk);
        #1;
        bus.rbk_rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.rbk_rsp_vld !== 1'b0 || bus.cvif2rbk_rd_rsp_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_rst: got vld=%b ready=%b want 0 1",
                     bus.rbk_rsp_vld, bus.cvif2rbk_rd_rsp_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (bus.rbk_rsp_vld !== 1'b0 || bus.cvif2rbk_rd_rsp_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL mid_noB: got vld=%b ready=%b want 0 1",
                         bus.rbk_rsp_vld, bus.cvif2rbk_rd_rsp_ready);
            end
        end
        @(posedge clk);
        #1;
        bus.cvif2rbk_rd_rsp_valid = 1'b1;
        bus.cvif2rbk_rd_rsp_pd = pc;
        @(posedge clk);
        #1;
        bus.cvif2rbk_rd_rsp_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.rbk_rsp_vld !== 1'b1 || bus.rbk_rsp_data !== pc[255:0] ||
            bus.rbk_rsp_last !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_next_lo: got vld=%b last=%b data=%h want 1 0 %h",
                     bus.rbk_rsp_vld, bus.rbk_rsp_last, bus.rbk_rsp_data, pc[255:0]);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.rbk_rsp_vld !== 1'b1 || bus.rbk_rsp_data !== pc[511:256] ||
            bus.rbk_rsp_last !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_next_hi: got vld=%b last=%b data=%h want 1 1 %h",
                     bus.rbk_rsp_vld, bus.rbk_rsp_last, bus.rbk_rsp_data, pc[511:256]);
        end
        settle();
    endtask

    initial begin
        bus.cvif2rbk_rd_rsp_valid = 1'b0;
        bus.cvif2rbk_rd_rsp_pd = '0;
        bus.rbk_rsp_rdy = 1'b0;
        test_reset();
        test_mask11();
        test_full();
        test_mask00();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
